data_mem_be: RTL
================

// Module: data_mem_be
// PURPOSE
//  Parametrised single-port data memory for the core's load/store unit.
//  - Supports byte, half-word and word accesses with per-byte write enables.
//  - Sign/zero-extends loads; flags misaligned, out-of-range and illegal-size accesses.
//  - Synchronous read with a req/gnt/rvalid handshake; fully pipelined, one access accepted per cycle.
//  - Optionally zeroes its whole array after reset.
// PARAMETERS
//  ADDR_W          32    byte-address width
//  NENTRIES        256   depth in 32-bit words; power of two, >=2
//  CLEAR_ON_RESET  1     1: run INIT sweep zeroing all words after reset; 0: skip INIT, contents undefined
// PORTS
//  clk_i       in   1       clock, rising edge
//  rst_i       in   1       reset, asynchronous, active-high
//  req_i       in   1       access request
//  we_i        in   1       1 = store, 0 = load
//  addr_i      in   ADDR_W  byte address
//  size_i      in   2       00 byte, 01 half, 10 word, 11 illegal
//  unsigned_i  in   1       loads: 1 zero-extend, 0 sign-extend
//  wdata_i     in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//  gnt_o       out  1       request accepted this cycle
//  rvalid_o    out  1       response valid, exactly 1 cycle after the grant
//  rdata_o     out  32      load result, extended
//  err_o       out  1       access error, qualified by rvalid_o
//  busy_o      out  1       INIT sweep in progress
// BEHAVIOUR
//  Reset values (asserted asynchronously):
//  - rvalid_o=0, rdata_o=0, err_o=0, FSM=INIT, clear counter=0.
//  - busy_o=CLEAR_ON_RESET.
//  - Reset mid-operation drops any in-flight response; no partial write occurs after reset asserts.
//  FSM:
//  - INIT: writes 0 to word[cnt] each cycle; cnt wraps at NENTRIES-1.
//    Moves to RUN on the cycle after the last write, taking NENTRIES cycles in total.
//    If CLEAR_ON_RESET=0, reset leaves the FSM directly in RUN.
//  - RUN: stays in RUN until reset.
//  Grant:
//  - gnt_o = req_i & (state==RUN), combinational. Requests are ignored in INIT.
//  Addressing:
//  - idx = addr_i[$clog2(NENTRIES)+1:2]; off = addr_i[1:0].
//  Error conditions (err=1):
//  - size_i==11.
//  - Half access with off[0]!=0.
//  - Word access with off!=0.
//  - Any nonzero bit in addr_i[ADDR_W-1:$clog2(NENTRIES)+2].
//  Store, granted at edge N:
//  - If no error, write the bytes selected by be at edge N.
//  - Byte enables: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111.
//  - Data replicated across lanes: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}.
//  - Response: after edge N, rvalid_o=1, rdata_o=0, err_o=err.
//  - On error, memory is unchanged.
//  Load, granted at edge N:
//  - Word read at edge N.
//  - Response: after edge N, rvalid_o=1, err_o=err.
//  - rdata_o = selected byte/half, shifted down by off*8 and extended per unsigned_i.
//  - Word loads are not extended. On error, rdata_o=0.
//  Outputs when idle: rvalid_o=0 in any cycle not following a grant, with rdata_o=0 and err_o=0.
//  Ordering:
//  - Single port, one access per cycle. Store then load to the same word on consecutive cycles
//    returns the new data; no forwarding is needed.
//  - Unselected bytes of a partial store are preserved.
//  Response throughput: back-to-back grants produce back-to-back rvalid_o pulses in request order.
// TESTING
//  1 Reset, CLEAR_ON_RESET=1 -> busy_o=1 for 256 cycles, gnt_o=0 during sweep; then load word 0x3FC -> 0x00000000.
//  2 Store word 0x100=0xDEADBEEF; store byte 0x101=0x5A; load word 0x100 -> 0xDEAD5AEF, err_o=0.
//  3 Load byte 0x103 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load half 0x102 signed -> 0xFFFFDEAD.
//  4 Store half 0x101 and store word 0x102 -> err_o=1 with rvalid_o, word 0x100 unchanged; size_i=11 -> err_o=1.
//  5 Store word 0x400 (out of range, NENTRIES=256) -> err_o=1; load 0x000 -> unchanged.
//  6 Back-to-back store 0x20=0x11223344 then load 0x20 -> rvalid_o on 2 consecutive cycles, load returns 0x11223344.
//    Assert rst_i between grant and response -> no rvalid_o, busy_o=1.

Source files
------------

// File: rtl/data_mem_be.sv
// Single-port byte-enabled data memory for the load/store unit.
// Synchronous read, one access granted per cycle; the response follows
// the grant by exactly one cycle. Optionally zero-fills the array after reset.
module data_mem_be #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned NENTRIES       = 256,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [31:0]       wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int unsigned IdxW = $clog2(NENTRIES);

  typedef enum logic {StInit, StRun} state_e;

  // Without a clear sweep the memory is usable straight out of reset.
  localparam state_e ResetState = CLEAR_ON_RESET ? StInit : StRun;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   cnt_q, cnt_d;

  logic [31:0]       mem_q [NENTRIES];

  // Request decode
  logic [IdxW-1:0]   idx;
  logic [1:0]        off;
  logic [ADDR_W-1:0] addr_hi;
  logic              req_err;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic              init_we;
  logic              st_we;
  logic              ld_re;

  // Response pipeline stage
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic              is_load_q, is_load_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              uns_q, uns_d;
  logic [31:0]       rword_q;
  logic [31:0]       rshift;

  // FSM and sweep counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ResetState;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep every word once, then stay in RUN until the next reset
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;  // wraps to 0 after the last word
        if (cnt_q == IdxW'(NENTRIES - 1)) begin
          state_d = StRun;
        end
      end
      StRun: state_d = StRun;
      default: state_d = ResetState;
    endcase
  end

  assign gnt_o  = req_i & (state_q == StRun);
  assign busy_o = (state_q == StInit);

  // Address split, error detection, lane enables and data replication
  always_comb begin
    idx       = addr_i[IdxW+1:2];
    off       = addr_i[1:0];
    addr_hi   = addr_i >> (IdxW + 2);
    req_err   = |addr_hi;
    be        = 4'b0000;
    wdata_rep = wdata_i;
    case (size_i)
      SizeByte: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata_i[7:0]}};
      end
      SizeHalf: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata_i[15:0]}};
        if (off[0]) req_err = 1'b1;
      end
      SizeWord: begin
        be        = 4'b1111;
        wdata_rep = wdata_i;
        if (off != 2'b00) req_err = 1'b1;
      end
      default: req_err = 1'b1;
    endcase
  end

  assign init_we = (state_q == StInit);
  assign st_we   = gnt_o & we_i & ~req_err;
  assign ld_re   = gnt_o & ~we_i;

  // Array write (sweep or store) and synchronous word read
  always_ff @(posedge clk_i) begin
    if (init_we) begin
      mem_q[cnt_q] <= '0;
    end else if (st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
    if (ld_re) begin
      rword_q <= mem_q[idx];
    end
  end

  // Capture what the response stage needs to format the result
  always_comb begin
    rvalid_d  = gnt_o;
    err_d     = gnt_o & req_err;
    is_load_d = gnt_o & ~we_i;
    size_d    = size_i;
    off_d     = off;
    uns_d     = unsigned_i;
  end

  // Response stage registers; reset drops any in-flight response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      is_load_q <= 1'b0;
      size_q    <= 2'b00;
      off_q     <= 2'b00;
      uns_q     <= 1'b0;
    end else begin
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      is_load_q <= is_load_d;
      size_q    <= size_d;
      off_q     <= off_d;
      uns_q     <= uns_d;
    end
  end

  // Align and extend the loaded word; zero for stores, errors and idle cycles
  always_comb begin
    rshift   = rword_q >> {off_q, 3'b000};
    rdata_o  = '0;
    rvalid_o = rvalid_q;
    err_o    = rvalid_q & err_q;
    if (rvalid_q && is_load_q && !err_q) begin
      case (size_q)
        SizeByte: rdata_o = uns_q ? {24'h0, rshift[7:0]}
                                  : {{24{rshift[7]}}, rshift[7:0]};
        SizeHalf: rdata_o = uns_q ? {16'h0, rshift[15:0]}
                                  : {{16{rshift[15]}}, rshift[15:0]};
        default:  rdata_o = rword_q;
      endcase
    end
  end

endmodule
